bcd2bin_seq: RTL and testbench

- Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from every BCD nibble >= 8.
- Takes six BCD digits (sgZ0 = units … sgZ5 = hundred-thousands) from the on-screen/LCD numeric entry path.
- Returns a 24-bit binary value for the SDRAM/camera control registers.
- Uses one iteration per clock, so no wide combinational chain sits on the pixel-clock domain.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_nib_sub3.sv | 9 +
 rtl/bcd2bin_seq.sv | 99 +++++++++
 tb/tb_bcd2bin_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, state encoding and digit check for the BCD-to-binary converter
package bcd_pkg;

    localparam int          BCD_DIGITS     = 6;
    localparam logic [23:0] BCD_MAX        = 24'd999999;
    localparam int          SHIFTS_DEFAULT = 20;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic digits_valid(input logic [4*BCD_DIGITS-1:0] d);
        digits_valid = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (d[4*i +: 4] > 4'd9) digits_valid = 1'b0;
    endfunction

endpackage

// File: rtl/bcd_nib_sub3.sv
// bcd_nib_sub3: reverse double-dabble nibble correction, subtract 3 when the nibble is 8 or more
module bcd_nib_sub3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd8) ? nib_i - 4'd3 : nib_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: six-digit BCD to binary converter, one reverse double-dabble iteration per clock
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 24,
    parameter int SHIFTS = SHIFTS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       sgZ0,
    input  logic [3:0]       sgZ1,
    input  logic [3:0]       sgZ2,
    input  logic [3:0]       sgZ3,
    input  logic [3:0]       sgZ4,
    input  logic [3:0]       sgZ5,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BIN_W-1:0] binary
);

    localparam int DW = 4*BCD_DIGITS;
    localparam int WW = DW + SHIFTS;
    localparam int CW = $clog2(SHIFTS);

    state_t             state_q, state_d;
    logic [WW-1:0]      w_q, w_d, w_sh, w_fix;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d, err_q, err_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [DW-1:0]      digits;

    assign digits = {sgZ5, sgZ4, sgZ3, sgZ2, sgZ1, sgZ0};
    assign w_sh   = w_q >> 1;
    assign w_fix[SHIFTS-1:0] = w_sh[SHIFTS-1:0];

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_nib
        bcd_nib_sub3 u_sub3 (
            .nib_i(w_sh[SHIFTS+4*g +: 4]),
            .nib_o(w_fix[SHIFTS+4*g +: 4])
        );
    end

    // Next-state: accept/validate a request in IDLE, iterate and publish the result in SHIFT
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        bin_d   = bin_q;
        if (state_q == ST_IDLE) begin
            if (start && !digits_valid(digits)) begin
                done_d = 1'b1;
                err_d  = 1'b1;
                bin_d  = '0;
            end else if (start) begin
                w_d     = {digits, {SHIFTS{1'b0}}};
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = ST_SHIFT;
            end
        end else begin
            w_d   = w_fix;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(SHIFTS-1)) begin
                bin_d   = BIN_W'(w_fix[SHIFTS-1:0]);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    // State register; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = done_q;
    assign err    = err_q;
    assign binary = bin_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed and swept checks of the sequential BCD-to-binary converter
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] dig = '0;
    logic        busy, done, err;
    logic [23:0] binary;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    bcd2bin_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .sgZ0(dig[3:0]), .sgZ1(dig[7:4]), .sgZ2(dig[11:8]),
        .sgZ3(dig[15:12]), .sgZ4(dig[19:16]), .sgZ5(dig[23:20]),
        .busy(busy), .done(done), .err(err), .binary(binary)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
        tests++; if (binary !== 24'd0) begin fails++; $display("FAIL reset_binary: got %0d want 0", binary); end
    endtask

    task automatic test_convert(input logic [23:0] d, input int expv, input string nm);
        int lat = 0;
        int bcnt;
        dig = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
            if (busy) bcnt++;
        end
        tests++; if (lat !== 20) begin fails++; $display("FAIL %s_latency: got %0d want 20", nm, lat); end
        tests++; if (bcnt !== 20) begin fails++; $display("FAIL %s_busy_cycles: got %0d want 20", nm, bcnt); end
        tests++; if (binary !== 24'(expv)) begin fails++; $display("FAIL %s_binary: got %0d want %0d", nm, binary, expv); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL %s_err: got %b want 0", nm, err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_at_done: got %b want 0", nm, busy); end
    endtask

    task automatic test_invalid();
        dig = 24'h00A000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL inv_done: got %b want 1", done); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL inv_err: got %b want 1", err); end
        tests++; if (binary !== 24'd0) begin fails++; $display("FAIL inv_binary: got %0d want 0", binary); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL inv_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL inv_done_pulse: got %b want 0", done); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL inv_err_held: got %b want 1", err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL inv_busy_after: got %b want 0", busy); end
        test_convert(24'h000042, 42, "after_err");
    endtask

    task automatic test_ignore_busy();
        int lat = 0;
        dig = 24'h000321;
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 40; k++) begin
            dig = (k % 2) ? 24'h999999 : 24'h0A0808;
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        start = 1'b0;
        tests++; if (lat !== 20) begin fails++; $display("FAIL busy_ign_latency: got %0d want 20", lat); end
        tests++; if (binary !== 24'd321) begin fails++; $display("FAIL busy_ign_binary: got %0d want 321", binary); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_ign_no_queue: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        dig = 24'h000555;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        tests++; if (binary !== 24'd555) begin fails++; $display("FAIL b2b_first: got %0d want 555", binary); end
        dig = 24'h000777;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got %b want 1", busy); end
        tests++; if (binary !== 24'd555) begin fails++; $display("FAIL b2b_hold: got %0d want 555", binary); end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        tests++; if (lat !== 20) begin fails++; $display("FAIL b2b_latency: got %0d want 20", lat); end
        tests++; if (binary !== 24'd777) begin fails++; $display("FAIL b2b_second: got %0d want 777", binary); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        dig = 24'h000999;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        tests++; if (binary !== 24'd0) begin fails++; $display("FAIL rstmid_binary: got %0d want 0", binary); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rstmid_done: got %b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", seen); end
        test_convert(24'h000100, 100, "after_rst");
    endtask

    task automatic test_sweep();
        int n;
        int lat;
        logic [23:0] d;
        for (int t = 0; t < 1000; t++) begin
            n = (t == 0) ? 999999 : (t == 1) ? 0 : int'($urandom_range(999999));
            for (int i = 0; i < 6; i++) d[4*i +: 4] = 4'((n / (10 ** i)) % 10);
            dig = d;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lat = 0;
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk); #1;
                if (done) begin lat = k; break; end
            end
            tests++; if (lat !== 20) begin fails++; $display("FAIL sweep_latency: got %0d want 20 for %0d", lat, n); end
            tests++; if (binary !== 24'(n)) begin fails++; $display("FAIL sweep_binary: got %0d want %0d", binary, n); end
        end
    endtask

    initial begin
        test_reset();
        test_convert(24'h999999, 999999, "all9");
        tests++; if (binary !== 24'h0F423F) begin fails++; $display("FAIL all9_hex: got %h want 0f423f", binary); end
        test_convert(24'h123456, 123456, "seq");
        tests++; if (binary !== 24'h01E240) begin fails++; $display("FAIL seq_hex: got %h want 01e240", binary); end
        test_convert(24'h000000, 0, "zero");
        test_invalid();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
